// File: rtl/spi_arb.sv
// Two-requester arbiter (INR high prio, A2D low prio) in front of one 16-bit SPI master.
// Latency: request pulse to wrt_o is 2 cycles; done_i to requester done pulse is 1 cycle.
// Backpressure: one pending slot per requester; a request while that slot is full is dropped and flagged on ovr_o.
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   inr_req_i / inr_cmd_i     INR request pulse + command word
//   inr_done_o / inr_resp_o   INR completion pulse + held response word
//   a2d_req_i / a2d_cmd_i     A2D request pulse + command word
//   a2d_done_o / a2d_resp_o   A2D completion pulse + held response word
//   wrt_o / cmd_o             start pulse + command to the SPI master
//   done_i / rd_data_i        SPI master completion pulse + read data
//   ovr_o                     dropped-request pulse
//   err_o                     timeout-abort pulse
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a transaction stuck in WAIT after
// TIMEOUT_CYC cycles (owner gets 16'hDEAD plus a done pulse, err_o pulses). Without it err_o is 0.
module spi_arb #(
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        inr_req_i,
  input  logic [15:0] inr_cmd_i,
  output logic        inr_done_o,
  output logic [15:0] inr_resp_o,
  input  logic        a2d_req_i,
  input  logic [15:0] a2d_cmd_i,
  output logic        a2d_done_o,
  output logic [15:0] a2d_resp_o,
  output logic        wrt_o,
  output logic [15:0] cmd_o,
  input  logic        done_i,
  input  logic [15:0] rd_data_i,
  output logic        ovr_o,
  output logic        err_o
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LAUNCH  = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic OWN_INR = 1'b0;
  localparam logic OWN_A2D = 1'b1;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        pend_inr_q, pend_inr_d;
  logic        pend_a2d_q, pend_a2d_d;
  logic [15:0] cmd_inr_q, cmd_inr_d;
  logic [15:0] cmd_a2d_q, cmd_a2d_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] inr_resp_q, inr_resp_d;
  logic [15:0] a2d_resp_q, a2d_resp_d;
  logic        inr_done_q, inr_done_d;
  logic        a2d_done_q, a2d_done_d;
  logic        ovr_q, ovr_d;
  logic [3:0]  starve_q, starve_d;

  logic        tmo_hit;
  logic        finish;
  logic [15:0] fin_data;
  logic        clr_inr;
  logic        clr_a2d;
  logic        pick_a2d;

  // A transaction ends on done_i, or on timeout when that feature is built in.
  // A real done in the same cycle as the timeout wins and delivers real data.
  assign finish   = (state_q == ST_WAIT) && (done_i || tmo_hit);
  assign fin_data = done_i ? rd_data_i : 16'hDEAD;
  assign clr_inr  = finish && (owner_q == OWN_INR);
  assign clr_a2d  = finish && (owner_q == OWN_A2D);

  // A2D only overtakes a pending INR once INR has won STARVE_MAX times in a row.
  assign pick_a2d = pend_a2d_q && (!pend_inr_q || (starve_q == STARVE_LIM));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    pend_inr_d = pend_inr_q;
    pend_a2d_d = pend_a2d_q;
    cmd_inr_d  = cmd_inr_q;
    cmd_a2d_d  = cmd_a2d_q;
    cmd_d      = cmd_q;
    inr_resp_d = inr_resp_q;
    a2d_resp_d = a2d_resp_q;
    inr_done_d = 1'b0;
    a2d_done_d = 1'b0;
    ovr_d      = 1'b0;
    starve_d   = starve_q;

    // Completion clears the pending slot; a request in the same cycle refills it.
    if (clr_inr) pend_inr_d = 1'b0;
    if (clr_a2d) pend_a2d_d = 1'b0;

    if (inr_req_i) begin
      if (!pend_inr_q || clr_inr) begin
        pend_inr_d = 1'b1;
        cmd_inr_d  = inr_cmd_i;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (a2d_req_i) begin
      if (!pend_a2d_q || clr_a2d) begin
        pend_a2d_d = 1'b1;
        cmd_a2d_d  = a2d_cmd_i;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (pend_inr_q || pend_a2d_q) begin
          state_d = ST_LAUNCH;
          if (pick_a2d) begin
            owner_d  = OWN_A2D;
            cmd_d    = cmd_a2d_q;
            starve_d = 4'd0;
          end else begin
            owner_d = OWN_INR;
            cmd_d   = cmd_inr_q;
            if (pend_a2d_q && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (finish) begin
          state_d = ST_RELEASE;
          if (owner_q == OWN_INR) begin
            inr_resp_d = fin_data;
            inr_done_d = 1'b1;
          end else begin
            a2d_resp_d = fin_data;
            a2d_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_INR;
      pend_inr_q <= 1'b0;
      pend_a2d_q <= 1'b0;
      cmd_inr_q  <= 16'h0000;
      cmd_a2d_q  <= 16'h0000;
      cmd_q      <= 16'h0000;
      inr_resp_q <= 16'h0000;
      a2d_resp_q <= 16'h0000;
      inr_done_q <= 1'b0;
      a2d_done_q <= 1'b0;
      ovr_q      <= 1'b0;
      starve_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      pend_inr_q <= pend_inr_d;
      pend_a2d_q <= pend_a2d_d;
      cmd_inr_q  <= cmd_inr_d;
      cmd_a2d_q  <= cmd_a2d_d;
      cmd_q      <= cmd_d;
      inr_resp_q <= inr_resp_d;
      a2d_resp_q <= a2d_resp_d;
      inr_done_q <= inr_done_d;
      a2d_done_q <= a2d_done_d;
      ovr_q      <= ovr_d;
      starve_q   <= starve_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Counter is at least 11 bits so the default 1024-cycle limit fits.
  localparam int TW = (TIMEOUT_CYC < 1024) ? 11 : $clog2(TIMEOUT_CYC) + 1;

  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  // Counts WAIT cycles; hit on the TIMEOUT_CYC-th WAIT cycle.
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_LAUNCH)    tmo_d = '0;
    else if (state_q == ST_WAIT) tmo_d = tmo_q + TW'(1);
    err_d = (state_q == ST_WAIT) && tmo_hit && !done_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYC;
  assign tmo_hit        = 1'b0;
  assign err_o          = 1'b0;
`endif

  assign wrt_o      = (state_q == ST_LAUNCH);
  assign cmd_o      = cmd_q;
  assign inr_done_o = inr_done_q;
  assign inr_resp_o = inr_resp_q;
  assign a2d_done_o = a2d_done_q;
  assign a2d_resp_o = a2d_resp_q;
  assign ovr_o      = ovr_q;

endmodule
